// File: rtl/mole_game_controller_pkg.sv
// rtl/mole_game_controller_pkg.sv - shared state encoding and LFSR helpers for the mole game core
package mole_game_controller_pkg;

    // Encodings are shared with the display driver, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_UP    = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Right-shift Galois taps for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Wide enough to index up to eight moles.
    localparam int IDX_W = 3;

    // Width of the per-mole up-window counter.
    localparam int UPCNT_W = 8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/mole_game_controller_lfsr.sv
// rtl/mole_game_controller_lfsr.sv - free-running 8-bit Galois LFSR used to pick moles
module mole_game_controller_lfsr
    import mole_game_controller_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] lfsr
);

    // Advance every cycle regardless of game state so the pick depends on start timing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/mole_game_controller.sv
// rtl/mole_game_controller.sv - whack-a-mole game FSM, scoring and game timer
module mole_game_controller
    import mole_game_controller_pkg::*;
#(
    parameter int         NUM_MOLES     = 5,
    parameter int         GAME_SECONDS  = 30,
    parameter int         MOLE_UP_TICKS = 2,
    parameter int         SCORE_WIDTH   = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   startPulse,
    input  logic [NUM_MOLES-1:0]   moleButtonPulses,
    output logic [NUM_MOLES-1:0]   moleLED,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [SCORE_WIDTH-1:0] misses,
    output logic [5:0]             timeLeft,
    output logic                   gameActive,
    output logic                   gameOver
);

    localparam logic [NUM_MOLES-1:0] ONE_LED = NUM_MOLES'(1);

    state_t             state;
    logic [7:0]         lfsr;
    logic [IDX_W-1:0]   prev_idx;
    logic [UPCNT_W-1:0] up_cnt;
    logic [IDX_W-1:0]   idx_raw;
    logic [IDX_W-1:0]   spawn_idx;
    logic [NUM_MOLES-1:0] spawn_led;
    logic               hit;
    logic               in_play;

    mole_game_controller_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr)
    );

    // Pick the next mole, never repeating the previous index, and detect hits on the lit mole.
    always_comb begin
        idx_raw   = IDX_W'(lfsr % 8'(NUM_MOLES));
        spawn_idx = idx_raw;
        if (idx_raw == prev_idx) begin
            spawn_idx = (idx_raw == IDX_W'(NUM_MOLES - 1)) ? '0 : idx_raw + IDX_W'(1);
        end
        spawn_led = ONE_LED << spawn_idx;
        hit       = |(moleButtonPulses & moleLED);
        in_play   = (state == ST_SPAWN) || (state == ST_UP);
    end

    // Game FSM with registered outputs; the timer block at the end overrides the mole logic on the final tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            moleLED    <= '0;
            score      <= '0;
            misses     <= '0;
            timeLeft   <= '0;
            gameActive <= 1'b0;
            gameOver   <= 1'b0;
            prev_idx   <= '0;
            up_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (startPulse) begin
                        score      <= '0;
                        misses     <= '0;
                        timeLeft   <= 6'(GAME_SECONDS);
                        state      <= ST_SPAWN;
                        gameActive <= 1'b1;
                        gameOver   <= 1'b0;
                    end
                end
                ST_SPAWN: begin
                    moleLED  <= spawn_led;
                    prev_idx <= spawn_idx;
                    up_cnt   <= UPCNT_W'(MOLE_UP_TICKS);
                    state    <= ST_UP;
                end
                ST_UP: begin
                    if (hit) begin
                        score   <= (score == '1) ? score : score + SCORE_WIDTH'(1);
                        moleLED <= '0;
                        state   <= ST_SPAWN;
                    end else if (tick) begin
                        if (up_cnt == UPCNT_W'(1)) begin
                            misses  <= (misses == '1) ? misses : misses + SCORE_WIDTH'(1);
                            moleLED <= '0;
                            state   <= ST_SPAWN;
                        end else begin
                            up_cnt <= up_cnt - UPCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (tick && in_play) begin
                if (timeLeft == 6'd1) begin
                    timeLeft   <= '0;
                    moleLED    <= '0;
                    state      <= ST_DONE;
                    gameActive <= 1'b0;
                    gameOver   <= 1'b1;
                end else begin
                    timeLeft <= timeLeft - 6'd1;
                end
            end
        end
    end

endmodule
